serial_subtractor: RTL and testbench

Multi-cycle, slice-serial subtractor computing d = c − a over WIDTH-bit unsigned operands, SLICE bits per clock, with valid/ready handshakes on both sides. It is the inverse companion of the registered adder: given a sum and one operand, it recovers the other operand and reports underflow. Area is traded for latency, so the block suits wide datapaths where a full-width carry chain is not wanted.

---
 rtl/serial_sub_pkg.sv | 20 ++
 rtl/slice_subtractor.sv | 19 +
 rtl/serial_subtractor.sv | 128 ++++++++++++
 tb/tb_serial_subtractor.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the slice-serial subtractor.
// Imported by the top level; the slice datapath needs nothing from here.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int nslices(input int width, input int slice);
        return width / slice;
    endfunction

    // Slice counter width; a single-slice build still gets a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/slice_subtractor.sv
// Combinational SLICE-bit subtract with borrow in/out: {bout, diff} = x - y - bin.
module slice_subtractor #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  logic             bin,
    output logic [SLICE-1:0] diff,
    output logic             bout
);

    logic [SLICE:0] full;

    // The extra top bit of the widened difference is set exactly when x < y + bin.
    assign full = {1'b0, x} - {1'b0, y} - {{SLICE{1'b0}}, bin};
    assign diff = full[SLICE-1:0];
    assign bout = full[SLICE];

endmodule

// File: rtl/serial_subtractor.sv
// Slice-serial unsigned subtractor d = c - a, SLICE bits per clock, LSB slice first,
// with valid/ready handshakes on operand and result sides.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 40,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             borrow
);

    localparam int             NS   = nslices(WIDTH, SLICE);
    localparam int             CW   = cnt_width(NS);
    localparam logic [CW-1:0]  LAST = CW'(NS - 1);

    if (WIDTH % SLICE != 0) begin : g_bad_width
        $error("serial_subtractor: WIDTH must be a multiple of SLICE");
    end

    state_e           state, next_state;
    logic             armed;
    logic [WIDTH-1:0] c_sr, a_sr;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             borrow_r;
    logic [SLICE-1:0] diff;
    logic             bout;
    logic             accept;
    logic             last_slice;

    slice_subtractor #(.SLICE(SLICE)) u_slice (
        .x    (c_sr[SLICE-1:0]),
        .y    (a_sr[SLICE-1:0]),
        .bin  (borrow_r),
        .diff (diff),
        .bout (bout)
    );

    // armed holds in_ready low until the first edge after reset release.
    assign in_ready   = armed && (state == IDLE);
    assign out_valid  = (state == DONE);
    assign accept     = in_valid && in_ready;
    assign last_slice = (cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= next_state;
            armed <= 1'b1;
        end
    end

    // NOTE: next_state is given a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)     next_state = RUN;
            RUN:     if (last_slice) next_state = DONE;
            DONE:    if (out_ready)  next_state = IDLE;
            default:                 next_state = IDLE;
        endcase
    end

    // Partial results enter from the top; the register only needs NS-1 slices
    // because the final slice goes straight into d.
    if (NS > 1) begin : g_multi
        logic [WIDTH-SLICE-1:0] res_sr;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                res_sr <= '0;
            end else if (state == RUN) begin
                res_sr <= res_next[WIDTH-1:SLICE];
            end
        end

        assign res_next = {diff, res_sr};
    end else begin : g_single
        assign res_next = diff;
    end

    // NOTE: the shift registers are reset like any other flop here; they are a few words, not a memory array.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_sr     <= '0;
            a_sr     <= '0;
            cnt      <= '0;
            borrow_r <= 1'b0;
            d        <= '0;
            borrow   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        c_sr     <= c;
                        a_sr     <= a;
                        cnt      <= '0;
                        borrow_r <= 1'b0;
                    end
                end
                RUN: begin
                    c_sr     <= c_sr >> SLICE;
                    a_sr     <= a_sr >> SLICE;
                    borrow_r <= bout;
                    cnt      <= cnt + CW'(1);
                    if (last_slice) begin
                        d      <= res_next;
                        borrow <= bout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: scoreboard queue of expected d/borrow,
// immediate-assertion checks, latency/backpressure/reset/back-to-back scenarios.
module tb_serial_subtractor;

    localparam int WIDTH = 40;
    localparam int SLICE = 8;
    localparam int NS    = WIDTH / SLICE;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             borrow;
    } result_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] a;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             borrow;

    int checks = 0;
    int errors = 0;
    result_t sb[$];

    serial_subtractor #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .c         (c),
        .a         (a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .borrow    (borrow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic result_t model(input logic [WIDTH-1:0] cc, input logic [WIDTH-1:0] aa);
        result_t r;
        r.d      = cc - aa;
        r.borrow = (cc < aa);
        return r;
    endfunction

    // Drive one operand pair at a negedge, wait (bounded) for in_ready, return after the accepting edge.
    task automatic send(input logic [WIDTH-1:0] cc, input logic [WIDTH-1:0] aa, input bit expect_out);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_ready_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        c        = cc;
        a        = aa;
        if (expect_out) sb.push_back(model(cc, aa));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Called at the negedge after the accept edge; waits for out_valid and compares against the scoreboard.
    task automatic wait_out(input string tag);
        int n = 0;
        result_t e;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(NS));
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_d"}, 64'(d), 64'(e.d));
            check({tag, "_borrow"}, 64'(borrow), 64'(e.borrow));
        end
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_ovalid_after_hs"}, 64'(out_valid), 64'd0);
        check({tag, "_iready_after_hs"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [WIDTH-1:0] held_d;
        logic             held_b;
        int               spurious;
        int               pulse_cyc[$];
        int               idx;
        bit               acc;
        logic [WIDTH-1:0] tc [2];
        logic [WIDTH-1:0] ta [2];

        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        c         = '0;
        a         = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_d", 64'(d), 64'd0);
        check("rst_borrow", 64'(borrow), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Basic subtraction and latency
        send(40'd100, 40'd42, 1'b1);
        wait_out("t100_42");
        handshake("t100_42");

        // Underflow to all-ones
        send(40'd0, 40'd1, 1'b1);
        wait_out("t0_1");
        handshake("t0_1");

        // Borrow ripples through four slices
        send(40'h01_0000_0000, 40'd1, 1'b1);
        wait_out("ripple");
        handshake("ripple");

        // Backpressure: hold DONE for 10 cycles while in_valid toggles
        send(40'd1000, 40'd1, 1'b1);
        wait_out("bp");
        held_d = d;
        held_b = borrow;
        for (int i = 0; i < 10; i++) begin
            in_valid = ~in_valid;
            c        = 40'(i * 3 + 11);
            a        = 40'(i);
            @(negedge clk);
            check("bp_d_stable", 64'(d), 64'(held_d));
            check("bp_borrow_stable", 64'(borrow), 64'(held_b));
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        handshake("bp");
        spurious = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) spurious++;
        end
        check("bp_no_capture", 64'(spurious), 64'd0);

        // Reset asserted at RUN cycle 3
        send(40'd50, 40'd20, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrun_rst_out_valid", 64'(out_valid), 64'd0);
        check("midrun_rst_d", 64'(d), 64'd0);
        check("midrun_rst_borrow", 64'(borrow), 64'd0);
        check("midrun_rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrun_post_in_ready", 64'(in_ready), 64'd1);
        spurious = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) spurious++;
        end
        check("midrun_no_out_valid", 64'(spurious), 64'd0);

        // Back-to-back with out_ready held high
        tc[0] = 40'd7; ta[0] = 40'd3;
        tc[1] = 40'd3; ta[1] = 40'd7;
        out_ready = 1'b1;
        idx       = 0;
        in_valid  = 1'b1;
        c         = tc[0];
        a         = ta[0];
        for (int cyc = 0; cyc < 40; cyc++) begin
            result_t e;
            if (out_valid) begin
                pulse_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    check("b2b_sb_empty", 64'(sb.size()), 64'd1);
                end else begin
                    e = sb.pop_front();
                    check("b2b_d", 64'(d), 64'(e.d));
                    check("b2b_borrow", 64'(borrow), 64'(e.borrow));
                end
            end
            acc = in_valid && in_ready;
            if (acc) sb.push_back(model(c, a));
            @(negedge clk);
            if (acc) begin
                idx++;
                if (idx < 2) begin
                    c = tc[idx];
                    a = ta[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        out_ready = 1'b0;
        check("b2b_pulse_count", 64'(pulse_cyc.size()), 64'd2);
        if (pulse_cyc.size() == 2)
            check("b2b_period", 64'(pulse_cyc[1] - pulse_cyc[0]), 64'(NS + 2));
        check("b2b_sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
